// File: rtl/if_stage.sv
// Instruction-fetch stage of the five-stage in-order pipeline.
// Owns the fetch PC and issues one outstanding read at a time on the
// SRAM-like instruction port. Each returned word goes into a single
// output slot, which is offered to decode as {pc, inst}.
// On a redirect from the decode branch bus, the stage moves the fetch PC
// to the target and throws away any fetch on the old path.
//
// Handshake semantics (both directions):
//   - Decode side: a slot transfer happens in a cycle where
//     fs_to_ds_valid && ds_allowin; the slot then empties at the edge
//     (unless refilled in that same cycle).
//   - Instruction port: a request is accepted in a cycle where
//     inst_sram_req && inst_sram_addr_ok; the slave samples
//     inst_sram_addr only in that cycle. Exactly one inst_sram_data_ok
//     follows each accepted request, at least one cycle later.
//   - fs_to_ds_valid is never qualified by ds_allowin, and inst_sram_req
//     is never qualified by inst_sram_addr_ok, so neither direction has a
//     combinational loop through the partner.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h1c00_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ds_allowin,
  input  logic [32:0] br_bus,
  output logic        fs_to_ds_valid,
  output logic [63:0] fs_to_ds_bus,
  output logic        inst_sram_req,
  output logic [31:0] inst_sram_addr,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata,
  output logic        dbg_state,
  output logic        dbg_cancel
);

  typedef enum logic {
    S_REQ  = 1'b0,
    S_WAIT = 1'b1
  } fs_state_e;

  // Branch bus fields
  logic        br_taken;
  logic [31:0] br_target;

  // Registered state and its next-state values
  fs_state_e   state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        cancel_q, cancel_d;
  logic        fs_valid_q, fs_valid_d;
  logic [31:0] fs_pc_q, fs_pc_d;
  logic [31:0] fs_inst_q, fs_inst_d;

  // Low during reset and until the first clock edge after release. This
  // keeps the address bus at zero while reset is held, even though
  // fetch_pc already holds RESET_PC.
  logic        run_q;

  // Handshake qualifiers
  logic        req;
  logic        addr_fire;
  logic        data_fire;
  logic        slot_drain;

  assign br_taken  = br_bus[32];
  assign br_target = br_bus[31:0];

  // Only ask for a new word when the slot is empty or is draining this
  // cycle. That way a returning word always finds the slot free and no
  // skid buffer is needed.
  assign req        = run_q && (state_q == S_REQ) && (!fs_valid_q || ds_allowin);
  assign addr_fire  = req && inst_sram_addr_ok;
  assign data_fire  = (state_q == S_WAIT) && inst_sram_data_ok;
  assign slot_drain = fs_valid_q && ds_allowin && !br_taken;

  assign inst_sram_req  = req;
  assign inst_sram_addr = run_q ? fetch_pc_q : 32'h0;

  // While a redirect is on the bus, the slot holds a wrong-path instruction
  // and must not be offered downstream.
  assign fs_to_ds_valid = fs_valid_q && !br_taken;
  assign fs_to_ds_bus   = {fs_pc_q, fs_inst_q};

  assign dbg_state  = state_q;
  assign dbg_cancel = cancel_q;

  // Output enable: becomes set at the first clock edge after reset is released
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      run_q <= 1'b0;
    end else begin
      run_q <= 1'b1;
    end
  end

  // State registers for the fetch FSM, the PCs and the output slot
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_REQ;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= 32'h0;
      cancel_q   <= 1'b0;
      fs_valid_q <= 1'b0;
      fs_pc_q    <= 32'h0;
      fs_inst_q  <= 32'h0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      cancel_q   <= cancel_d;
      fs_valid_q <= fs_valid_d;
      fs_pc_q    <= fs_pc_d;
      fs_inst_q  <= fs_inst_d;
    end
  end

  // Next state: request/response sequencing, slot fill/drain, then redirect
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    cancel_d   = cancel_q;
    fs_valid_d = fs_valid_q;
    fs_pc_d    = fs_pc_q;
    fs_inst_d  = fs_inst_q;

    // The slot empties on a transfer. A refill later in this block overrides it.
    if (slot_drain) begin
      fs_valid_d = 1'b0;
    end

    case (state_q)
      S_REQ: begin
        if (addr_fire) begin
          req_pc_d   = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + 32'd4;
          state_d    = S_WAIT;
          // An old-path request accepted together with a redirect
          // still returns a word. That word must be dropped.
          if (br_taken) begin
            cancel_d = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (data_fire) begin
          state_d = S_REQ;
          if (cancel_q || br_taken) begin
            cancel_d = 1'b0;
          end else begin
            fs_valid_d = 1'b1;
            fs_pc_d    = req_pc_q;
            fs_inst_d  = inst_sram_rdata;
          end
        end else if (br_taken) begin
          cancel_d = 1'b1;
        end
      end
      default: begin
        state_d = S_REQ;
      end
    endcase

    // A redirect overrides any handshake-driven fetch_pc update and kills
    // the slot, because the slot instruction is younger than the branch.
    if (br_taken) begin
      fetch_pc_d = br_target;
      fs_valid_d = 1'b0;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed testbench for if_stage. A bench-side instruction slave answers
// requests with data = ~addr after a programmable latency. Expected request
// addresses and delivered {pc, inst} pairs are queued by the stimulus and
// checked by independent monitors.
module tb_if_stage;

  localparam logic [31:0] RESET_PC = 32'h1c00_0000;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ds_allowin;
  logic [32:0] br_bus;
  logic        fs_to_ds_valid;
  logic [63:0] fs_to_ds_bus;
  logic        inst_sram_req;
  logic [31:0] inst_sram_addr;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        dbg_state;
  logic        dbg_cancel;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;

  logic [63:0] exp_q[$];
  logic [31:0] exp_addr_q[$];
  logic [63:0] mon_exp;
  logic [31:0] sl_exp;

  bit          sl_accept_en = 1'b0;
  int          sl_latency   = 1;

  if_stage #(.RESET_PC(RESET_PC)) dut (
    .clk               (clk),
    .resetn            (resetn),
    .ds_allowin        (ds_allowin),
    .br_bus            (br_bus),
    .fs_to_ds_valid    (fs_to_ds_valid),
    .fs_to_ds_bus      (fs_to_ds_bus),
    .inst_sram_req     (inst_sram_req),
    .inst_sram_addr    (inst_sram_addr),
    .inst_sram_addr_ok (inst_sram_addr_ok),
    .inst_sram_data_ok (inst_sram_data_ok),
    .inst_sram_rdata   (inst_sram_rdata),
    .dbg_state         (dbg_state),
    .dbg_cancel        (dbg_cancel)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Instruction slave: decisions are made 2 time units after each rising edge
  initial begin : slave
    bit          pending;
    int          cnt;
    logic [31:0] paddr;
    pending = 1'b0;
    cnt = 0;
    paddr = 32'h0;
    inst_sram_addr_ok = 1'b0;
    inst_sram_data_ok = 1'b0;
    inst_sram_rdata = 32'h0;
    forever begin
      @(posedge clk);
      #2;
      inst_sram_addr_ok = 1'b0;
      inst_sram_data_ok = 1'b0;
      if (!resetn) begin
        pending = 1'b0;
      end else if (pending) begin
        if (cnt == 0) begin
          inst_sram_data_ok = 1'b1;
          inst_sram_rdata = ~paddr;
          pending = 1'b0;
        end else begin
          cnt--;
        end
      end else if (inst_sram_req && sl_accept_en) begin
        inst_sram_addr_ok = 1'b1;
        pending = 1'b1;
        paddr = inst_sram_addr;
        cnt = sl_latency - 1;
        n_checks++;
        if (exp_addr_q.size() == 0) begin
          n_fail++;
          $display("FAIL req_addr: got unexpected request %h, required none", inst_sram_addr);
        end else begin
          sl_exp = exp_addr_q.pop_front();
          if (inst_sram_addr !== sl_exp) begin
            n_fail++;
            $display("FAIL req_addr: got %h, required %h", inst_sram_addr, sl_exp);
          end
        end
      end
    end
  end

  // Delivery monitor: every decode-side transfer must match the next expected pair
  always @(negedge clk) begin
    if (resetn && fs_to_ds_valid && ds_allowin) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL deliver: got unexpected {pc,inst}=%h, required none", fs_to_ds_bus);
      end else begin
        mon_exp = exp_q.pop_front();
        if (fs_to_ds_bus !== mon_exp) begin
          n_fail++;
          $display("FAIL deliver: got %h, required %h", fs_to_ds_bus, mon_exp);
        end
      end
    end
  end

  task automatic wait_accept(output int c);
    bit found;
    found = 1'b0;
    c = -1;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      if (inst_sram_req && inst_sram_addr_ok) begin
        found = 1'b1;
        c = cyc;
      end
    end
    check("accept_seen", {63'h0, found}, 64'h1);
  endtask

  task automatic fetch_one(input logic [31:0] a, input int lat,
                           input bit deliver, input logic [63:0] pair);
    int c;
    sl_latency = lat;
    exp_addr_q.push_back(a);
    if (deliver) exp_q.push_back(pair);
    sl_accept_en = 1'b1;
    wait_accept(c);
    sl_accept_en = 1'b0;
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, "_req"},   {63'h0, inst_sram_req}, 64'h0);
    check({name, "_addr"},  {32'h0, inst_sram_addr}, 64'h0);
    check({name, "_valid"}, {63'h0, fs_to_ds_valid}, 64'h0);
    check({name, "_bus"},   fs_to_ds_bus, 64'h0);
    check({name, "_dbg"},   {62'h0, dbg_state, dbg_cancel}, 64'h0);
  endtask

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  // Directed stimulus
  initial begin
    int c0, c1, c2, cr;
    resetn = 1'b0;
    ds_allowin = 1'b0;
    br_bus = 33'h0;

    // Reset state
    @(negedge clk);
    check_outputs_zero("reset");

    // Zero-wait streaming
    @(posedge clk); #1;
    ds_allowin = 1'b1;
    sl_latency = 1;
    exp_addr_q.push_back(32'h1c00_0000);
    exp_addr_q.push_back(32'h1c00_0004);
    exp_addr_q.push_back(32'h1c00_0008);
    exp_q.push_back({32'h1c00_0000, 32'he3ff_ffff});
    exp_q.push_back({32'h1c00_0004, 32'he3ff_fffb});
    exp_q.push_back({32'h1c00_0008, 32'he3ff_fff7});
    sl_accept_en = 1'b1;
    resetn = 1'b1;
    @(negedge clk);
    check("req_before_first_edge", {63'h0, inst_sram_req}, 64'h0);
    cr = cyc;
    wait_accept(c0);
    wait_accept(c1);
    wait_accept(c2);
    sl_accept_en = 1'b0;
    check("first_req_cycle", 64'(c0 - cr), 64'd1);
    check("spacing_0_1", 64'(c1 - c0), 64'd2);
    check("spacing_1_2", 64'(c2 - c1), 64'd2);
    repeat (3) @(negedge clk);

    // Backpressure with a full slot
    @(posedge clk); #1;
    ds_allowin = 1'b0;
    fetch_one(32'h1c00_000c, 1, 1'b0, 64'h0);
    @(negedge clk);
    check("valid_at_t_k", {63'h0, fs_to_ds_valid}, 64'h0);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check("bp_req", {63'h0, inst_sram_req}, 64'h0);
      check("bp_valid", {63'h0, fs_to_ds_valid}, 64'h1);
      check("bp_bus", fs_to_ds_bus, {32'h1c00_000c, 32'he3ff_fff3});
      @(negedge clk);
    end
    @(posedge clk); #1;
    exp_q.push_back({32'h1c00_000c, 32'he3ff_fff3});
    ds_allowin = 1'b1;
    @(negedge clk);
    check("req_on_allowin", {63'h0, inst_sram_req}, 64'h1);

    // Redirect during WAIT, data_ok three cycles later
    fetch_one(32'h1c00_0010, 4, 1'b0, 64'h0);
    @(posedge clk); #1;
    br_bus = {1'b1, 32'h1c00_0100};
    @(negedge clk);
    check("brw_state_wait", {63'h0, dbg_state}, 64'h1);
    check("brw_valid", {63'h0, fs_to_ds_valid}, 64'h0);
    @(posedge clk); #1;
    br_bus = 33'h0;
    @(negedge clk);
    check("brw_cancel_set", {63'h0, dbg_cancel}, 64'h1);
    check("brw_req_wait", {63'h0, inst_sram_req}, 64'h0);
    repeat (3) @(negedge clk);
    check("brw_cancel_clr", {63'h0, dbg_cancel}, 64'h0);
    check("brw_req", {63'h0, inst_sram_req}, 64'h1);
    check("brw_addr", {32'h0, inst_sram_addr}, {32'h0, 32'h1c00_0100});
    check("brw_valid_after", {63'h0, fs_to_ds_valid}, 64'h0);
    fetch_one(32'h1c00_0100, 1, 1'b1, {32'h1c00_0100, 32'he3ff_feff});
    repeat (2) @(negedge clk);

    // Redirect coincident with data_ok
    fetch_one(32'h1c00_0104, 2, 1'b0, 64'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    br_bus = {1'b1, 32'h1c00_0200};
    @(negedge clk);
    check("brd_valid", {63'h0, fs_to_ds_valid}, 64'h0);
    @(posedge clk); #1;
    br_bus = 33'h0;
    @(negedge clk);
    check("brd_cancel", {63'h0, dbg_cancel}, 64'h0);
    check("brd_state_req", {63'h0, dbg_state}, 64'h0);
    check("brd_req", {63'h0, inst_sram_req}, 64'h1);
    check("brd_addr", {32'h0, inst_sram_addr}, {32'h0, 32'h1c00_0200});
    check("brd_valid_after", {63'h0, fs_to_ds_valid}, 64'h0);

    // Redirect coincident with addr_ok while the slot is full
    fetch_one(32'h1c00_0200, 1, 1'b0, 64'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    sl_latency = 1;
    exp_addr_q.push_back(32'h1c00_0204);
    sl_accept_en = 1'b1;
    br_bus = {1'b1, 32'h1c00_0300};
    @(negedge clk);
    check("bra_valid", {63'h0, fs_to_ds_valid}, 64'h0);
    check("bra_slot_bus", fs_to_ds_bus, {32'h1c00_0200, 32'he3ff_fdff});
    check("bra_accept", {63'h0, inst_sram_req && inst_sram_addr_ok}, 64'h1);
    @(posedge clk); #1;
    br_bus = 33'h0;
    sl_accept_en = 1'b0;
    @(negedge clk);
    check("bra_state_wait", {63'h0, dbg_state}, 64'h1);
    check("bra_cancel_set", {63'h0, dbg_cancel}, 64'h1);
    @(negedge clk);
    check("bra_cancel_clr", {63'h0, dbg_cancel}, 64'h0);
    check("bra_req", {63'h0, inst_sram_req}, 64'h1);
    check("bra_addr", {32'h0, inst_sram_addr}, {32'h0, 32'h1c00_0300});
    check("bra_valid_after", {63'h0, fs_to_ds_valid}, 64'h0);
    fetch_one(32'h1c00_0300, 1, 1'b1, {32'h1c00_0300, 32'he3ff_fcff});
    repeat (2) @(negedge clk);

    // Asynchronous reset with a full slot
    @(posedge clk); #1;
    ds_allowin = 1'b0;
    fetch_one(32'h1c00_0304, 1, 1'b0, 64'h0);
    repeat (2) @(negedge clk);
    check("rs_full_bus", fs_to_ds_bus, {32'h1c00_0304, 32'he3ff_fcfb});
    check("rs_full_valid", {63'h0, fs_to_ds_valid}, 64'h1);
    #2;
    resetn = 1'b0;
    #1;
    check_outputs_zero("rs_full_async");
    @(negedge clk);
    check_outputs_zero("rs_full_held");
    @(posedge clk); #1;
    ds_allowin = 1'b1;
    resetn = 1'b1;
    @(negedge clk);
    check("rs_full_req_pre", {63'h0, inst_sram_req}, 64'h0);
    @(negedge clk);
    check("rs_full_req", {63'h0, inst_sram_req}, 64'h1);
    check("rs_full_addr", {32'h0, inst_sram_addr}, {32'h0, RESET_PC});

    // Asynchronous reset in WAIT
    fetch_one(RESET_PC, 3, 1'b0, 64'h0);
    @(negedge clk);
    check("rs_wait_state", {63'h0, dbg_state}, 64'h1);
    #2;
    resetn = 1'b0;
    #1;
    check_outputs_zero("rs_wait_async");
    @(posedge clk); #1;
    @(posedge clk); #1;
    resetn = 1'b1;
    @(negedge clk);
    check("rs_wait_req_pre", {63'h0, inst_sram_req}, 64'h0);
    @(negedge clk);
    check("rs_wait_req", {63'h0, inst_sram_req}, 64'h1);
    check("rs_wait_addr", {32'h0, inst_sram_addr}, {32'h0, RESET_PC});
    check("rs_wait_state_req", {63'h0, dbg_state}, 64'h0);
    fetch_one(RESET_PC, 1, 1'b1, {32'h1c00_0000, 32'he3ff_ffff});
    repeat (3) @(negedge clk);

    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    check("exp_addr_q_drained", 64'(exp_addr_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
